// File: rtl/scanline_fx_pkg.sv
// rtl/scanline_fx_pkg.sv - shared constants and types for the scanline effect
package scanline_fx_pkg;

    localparam int LATENCY = 2;

    typedef logic [2:0] level_t;
    typedef logic [7:0] pix_t;

endpackage

// File: rtl/scanline_atten.sv
// rtl/scanline_atten.sv - one colour channel: registered c*(8-L)/8 when darkened
module scanline_atten (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] pix_in,
    input  logic       darken,
    input  logic [2:0] level,
    output logic [7:0] pix_out
);

    logic [3:0]  scale;
    logic [11:0] product;
    logic [7:0]  pix_next;

    // scale of 8 is unity, so undarkened pixels share the same datapath
    assign scale    = darken ? (4'd8 - {1'b0, level}) : 4'd8;
    assign product  = {8'd0, scale} * {4'd0, pix_in};
    assign pix_next = 8'(product >> 3);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pix_out <= 8'd0;
        end else begin
            pix_out <= pix_next;
        end
    end

endmodule

// File: rtl/scanline_fx.sv
// rtl/scanline_fx.sv - two-stage colour expansion and scanline darkening pipeline
module scanline_fx
    import scanline_fx_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int LINE_CNT_W = 11
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ce_pix,
    input  logic [IN_W-1:0]       R,
    input  logic [IN_W-1:0]       G,
    input  logic [IN_W-1:0]       B,
    input  logic                  mono,
    input  logic                  HSync,
    input  logic                  VSync,
    input  logic                  HBlank,
    input  logic                  VBlank,
    input  logic                  scan_en,
    input  logic [2:0]            scan_level,
    input  logic                  scan_phase,
    input  logic                  scan_interlace,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_DE,
    output logic                  ce_pix_out,
    output logic [LINE_CNT_W-1:0] line_cnt
);

    function automatic pix_t expand(input logic [IN_W-1:0] c);
        pix_t e;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[IN_W-1-(i % IN_W)];
        end
        return e;
    endfunction

    logic   hs_d, vs_d, hb_d, vb_d, hist_valid;
    logic   hs_fall, vs_fall, act_start, act_end;
    logic   parity, field, de_state, de_now, darken_now;
    level_t level_q;

    logic   hs1, vs1, de1, ce1, darken1;
    level_t level1;
    pix_t   r1, g1, b1;

    // edges only count once a full cycle of history has been sampled
    assign hs_fall   = hist_valid & hs_d & ~HSync;
    assign vs_fall   = hist_valid & vs_d & ~VSync;
    assign act_start = hist_valid & hb_d & ~HBlank;
    assign act_end   = hist_valid & ~hb_d & HBlank;

    assign darken_now = scan_en & (parity == (scan_phase ^ (scan_interlace & field)));

    always_comb begin
        de_now = de_state;
        if (act_start) begin
            de_now = ~vb_d;
        end else if (act_end) begin
            de_now = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_d       <= 1'b0;
            vs_d       <= 1'b0;
            hb_d       <= 1'b0;
            vb_d       <= 1'b0;
            hist_valid <= 1'b0;
            parity     <= 1'b0;
            field      <= 1'b0;
            level_q    <= '0;
            de_state   <= 1'b0;
            line_cnt   <= '0;
        end else begin
            hs_d       <= HSync;
            vs_d       <= VSync;
            hb_d       <= HBlank;
            vb_d       <= VBlank;
            hist_valid <= 1'b1;
            de_state   <= de_now;
            // a frame start outranks a coincident line start
            if (vs_fall) begin
                parity  <= 1'b0;
                field   <= ~field;
                level_q <= scan_level;
            end else if (hs_fall) begin
                parity <= ~parity;
            end
            if (vs_fall) begin
                line_cnt <= '0;
            end else if (act_end && de_state && (line_cnt != '1)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    // stage 1: expansion, mono mux and blanking
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r1      <= '0;
            g1      <= '0;
            b1      <= '0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            de1     <= 1'b0;
            ce1     <= 1'b0;
            darken1 <= 1'b0;
            level1  <= '0;
        end else begin
            r1      <= de_now ? expand(mono ? G : R) : 8'd0;
            g1      <= de_now ? expand(G) : 8'd0;
            b1      <= de_now ? expand(mono ? G : B) : 8'd0;
            hs1     <= HSync;
            vs1     <= VSync;
            de1     <= de_now;
            ce1     <= ce_pix;
            darken1 <= darken_now;
            level1  <= level_q;
        end
    end

    // stage 2: attenuation and timing realignment
    scanline_atten u_atten_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pix_in  (r1),
        .darken  (darken1),
        .level   (level1),
        .pix_out (VGA_R)
    );

    scanline_atten u_atten_g (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pix_in  (g1),
        .darken  (darken1),
        .level   (level1),
        .pix_out (VGA_G)
    );

    scanline_atten u_atten_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pix_in  (b1),
        .darken  (darken1),
        .level   (level1),
        .pix_out (VGA_B)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            VGA_HS     <= 1'b0;
            VGA_VS     <= 1'b0;
            VGA_DE     <= 1'b0;
            ce_pix_out <= 1'b0;
        end else begin
            VGA_HS     <= hs1;
            VGA_VS     <= vs1;
            VGA_DE     <= de1;
            ce_pix_out <= ce1;
        end
    end

endmodule

// File: tb/tb_scanline_fx.sv
// tb/tb_scanline_fx.sv - directed self-checking bench for scanline_fx
module tb_scanline_fx;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic [3:0] R = 4'd0, G = 4'd0, B = 4'd0;
    logic       mono = 1'b0;
    logic       HSync = 1'b0, VSync = 1'b0, HBlank = 1'b1, VBlank = 1'b0;
    logic       scan_en = 1'b0;
    logic [2:0] scan_level = 3'd0;
    logic       scan_phase = 1'b0, scan_interlace = 1'b0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_DE, ce_pix_out;
    logic [3:0] line_cnt;

    int total = 0;
    int bad = 0;

    scanline_fx #(.IN_W(4), .LINE_CNT_W(4)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce_pix         (ce_pix),
        .R              (R),
        .G              (G),
        .B              (B),
        .mono           (mono),
        .HSync          (HSync),
        .VSync          (VSync),
        .HBlank         (HBlank),
        .VBlank         (VBlank),
        .scan_en        (scan_en),
        .scan_level     (scan_level),
        .scan_phase     (scan_phase),
        .scan_interlace (scan_interlace),
        .VGA_R          (VGA_R),
        .VGA_G          (VGA_G),
        .VGA_B          (VGA_B),
        .VGA_HS         (VGA_HS),
        .VGA_VS         (VGA_VS),
        .VGA_DE         (VGA_DE),
        .ce_pix_out     (ce_pix_out),
        .line_cnt       (line_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hs_pulse();
        HSync = 1'b1; step();
        HSync = 1'b0; step();
    endtask

    task automatic vs_pulse();
        VSync = 1'b1; step();
        VSync = 1'b0; step();
    endtask

    task automatic run_line(input string tag, input logic [3:0] r, input logic [3:0] g,
                            input logic [3:0] b, input logic [7:0] er, input logic [7:0] eg,
                            input logic [7:0] eb, input logic ede);
        R = r; G = g; B = b; HBlank = 1'b0;
        step(); step();
        chk({tag, "_de"}, VGA_DE, ede);
        chk({tag, "_r"}, VGA_R, er);
        chk({tag, "_g"}, VGA_G, eg);
        chk({tag, "_b"}, VGA_B, eb);
        HBlank = 1'b1;
        step(); step(); step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_r"}, VGA_R, 8'h00);
        chk({tag, "_g"}, VGA_G, 8'h00);
        chk({tag, "_b"}, VGA_B, 8'h00);
        chk({tag, "_hs"}, VGA_HS, 1'b0);
        chk({tag, "_vs"}, VGA_VS, 1'b0);
        chk({tag, "_de"}, VGA_DE, 1'b0);
        chk({tag, "_ce"}, ce_pix_out, 1'b0);
        chk({tag, "_lc"}, line_cnt, 4'd0);
    endtask

    initial begin
        // reset holds outputs low even with active inputs
        HSync = 1'b1; ce_pix = 1'b1;
        step(); step();
        check_all_zero("rst");
        HSync = 1'b0; ce_pix = 1'b0;
        reset = 1'b0;
        step();

        // two-cycle timing latency; the coincident fall leaves parity 0, field 1
        HSync = 1'b1; VSync = 1'b1; ce_pix = 1'b1;
        step();
        chk("lat1_hs", VGA_HS, 1'b0);
        chk("lat1_ce", ce_pix_out, 1'b0);
        step();
        chk("lat2_hs", VGA_HS, 1'b1);
        chk("lat2_vs", VGA_VS, 1'b1);
        chk("lat2_ce", ce_pix_out, 1'b1);
        HSync = 1'b0; VSync = 1'b0; ce_pix = 1'b0;
        step(); step();

        run_line("expand", 4'hA, 4'h5, 4'h3, 8'hAA, 8'h55, 8'h33, 1'b1);
        mono = 1'b1;
        run_line("mono", 4'hA, 4'h5, 4'h3, 8'h55, 8'h55, 8'h55, 1'b1);
        mono = 1'b0;
        chk("lc_two", line_cnt, 4'd2);

        VBlank = 1'b1; step();
        run_line("vblank", 4'hA, 4'h5, 4'h3, 8'h00, 8'h00, 8'h00, 1'b0);
        VBlank = 1'b0; step();
        chk("lc_vblank", line_cnt, 4'd2);

        // level 4 latched; field now 0, darken parity 0
        scan_level = 3'd4;
        vs_pulse();
        chk("lc_vsclr", line_cnt, 4'd0);
        scan_en = 1'b1;
        run_line("l4_p0", 4'hA, 4'hF, 4'h0, 8'h55, 8'h7F, 8'h00, 1'b1);
        hs_pulse();
        run_line("l4_p1", 4'hA, 4'hF, 4'h0, 8'hAA, 8'hFF, 8'h00, 1'b1);
        hs_pulse();
        run_line("l4_p0b", 4'hA, 4'hF, 4'h0, 8'h55, 8'h7F, 8'h00, 1'b1);

        // mid-frame level change is deferred to the next frame
        scan_level = 3'd7;
        hs_pulse();
        run_line("mid_p1", 4'hA, 4'hF, 4'h0, 8'hAA, 8'hFF, 8'h00, 1'b1);
        hs_pulse();
        run_line("mid_p0", 4'hA, 4'hF, 4'h0, 8'h55, 8'h7F, 8'h00, 1'b1);
        vs_pulse();
        run_line("l7_p0", 4'hA, 4'hF, 4'h0, 8'h15, 8'h1F, 8'h00, 1'b1);

        // interlace: field 1 darkens parity 1, field 0 darkens parity 0
        scan_interlace = 1'b1;
        run_line("il_f1p0", 4'hA, 4'hF, 4'h0, 8'hAA, 8'hFF, 8'h00, 1'b1);
        hs_pulse();
        run_line("il_f1p1", 4'hA, 4'hF, 4'h0, 8'h15, 8'h1F, 8'h00, 1'b1);
        HSync = 1'b1; VSync = 1'b1; step();
        HSync = 1'b0; VSync = 1'b0; step();
        run_line("il_f0p0", 4'hA, 4'hF, 4'h0, 8'h15, 8'h1F, 8'h00, 1'b1);
        hs_pulse();
        run_line("il_f0p1", 4'hA, 4'hF, 4'h0, 8'hAA, 8'hFF, 8'h00, 1'b1);

        // line counter saturation
        scan_en = 1'b0; scan_interlace = 1'b0;
        vs_pulse();
        chk("sat_clr", line_cnt, 4'd0);
        for (int i = 0; i < 20; i++) begin
            HBlank = 1'b0; step(); step();
            HBlank = 1'b1; step(); step();
        end
        chk("sat_15", line_cnt, 4'd15);
        vs_pulse();
        chk("sat_vsclr", line_cnt, 4'd0);
        for (int i = 0; i < 3; i++) begin
            HBlank = 1'b0; step(); step();
            HBlank = 1'b1; step(); step();
        end
        chk("lc_three", line_cnt, 4'd3);

        // mid-line reset
        R = 4'hA; G = 4'h5; B = 4'h3; HBlank = 1'b0;
        step(); step();
        chk("pre_rst_de", VGA_DE, 1'b1);
        chk("pre_rst_r", VGA_R, 8'hAA);
        reset = 1'b1; step();
        check_all_zero("midrst");
        reset = 1'b0;
        step(); step(); step();
        chk("post_rst_de", VGA_DE, 1'b0);
        chk("post_rst_r", VGA_R, 8'h00);
        HBlank = 1'b1; step();
        HBlank = 1'b0; step(); step();
        chk("resume_de", VGA_DE, 1'b1);
        chk("resume_r", VGA_R, 8'hAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
